interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
Parameters:
REQ-001 The block SHALL have parameter COUNT_W, default 4, giving the width of the interval value and countdown counter.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port sys_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_timer, input, 1 bit: one-cycle request to time the interval selected by interval_sel.
REQ-005 The block SHALL have port interval_sel, input, 2 bits: requested interval (00 base, 01 extended, 10 yellow, 11 undefined).
REQ-006 The block SHALL have port prg_sync_in, input, 1 bit: parameter store is being reprogrammed, so its read output is frozen.
REQ-007 The block SHALL have port param_value, input, COUNT_W bits: registered read data from the parameter store, valid one cycle after the address is presented with prg_sync_in low.
REQ-008 The block SHALL have port one_hz_enable, input, 1 bit: one-cycle-wide 1 Hz tick.
REQ-009 The block SHALL have port interval_address, output, 2 bits: read address driven to the parameter store.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port time_left, output, COUNT_W bits: current countdown value.
REQ-012 The block SHALL have port expired, output, 1 bit: one-cycle pulse when the interval elapses.

Function
REQ-013 The state machine SHALL have states IDLE, FETCH, LOAD and COUNT.
REQ-014 In IDLE, start_timer=1 SHALL register interval_sel into interval_address and move to FETCH.
REQ-015 In FETCH, the block SHALL hold while prg_sync_in=1 and move to LOAD on the first edge that samples prg_sync_in=0.
REQ-016 In LOAD, the block SHALL copy param_value into time_left and move to COUNT; if param_value=0, it SHALL instead pulse expired and return to IDLE.
REQ-017 In COUNT, each one_hz_enable SHALL decrement time_left by 1; a cycle with no tick SHALL hold the value.
REQ-018 A tick with time_left=1 SHALL set time_left to 0, pulse expired in the next cycle, and return to IDLE.
REQ-019 time_left SHALL never wrap below 0.
REQ-020 Ticks arriving in IDLE, FETCH or LOAD SHALL be ignored.
REQ-021 start_timer in FETCH, LOAD or COUNT SHALL abort the current interval, re-register interval_sel and go to FETCH with no expired pulse.
REQ-022 If start_timer coincides with the final tick, the restart SHALL win and expired SHALL not pulse.
REQ-023 interval_sel=11 SHALL be passed through unchanged; the returned value (15) SHALL be timed normally.
REQ-024 Latency SHALL be fixed: with prg_sync_in low, start_timer at edge N gives time_left valid and busy=1 after edge N+2.
REQ-025 In IDLE, time_left SHALL hold its last value.

Reset
REQ-026 sys_reset SHALL immediately force state to IDLE, interval_address=00, time_left=0, expired=0 and busy=0.
REQ-027 Reset asserted in mid-interval SHALL discard the interval with no expired pulse.
REQ-028 After reset deasserts, the block SHALL require a fresh start_timer before it does anything.

Structure
REQ-029 The interval address codes (BASE 00, EXTD 01, YELL 10) and the state encoding SHALL live in a shared package that the parameter store and the controller FSM also use.
REQ-030 The block SHALL be a single module with no sub-modules; the countdown counter SHALL stay inline.

Verification
REQ-031 Scenario: reset, then start_timer with sel=00 and param_value=6, followed by 6 ticks -> time_left steps 6,5,4,3,2,1,0, with exactly one expired pulse after the 6th tick.
REQ-032 Scenario: start_timer with sel=10 while prg_sync_in is held high for 5 cycles -> block stays in FETCH, then time_left=2 two edges after prg_sync_in falls.
REQ-033 Scenario: restart with sel=01 (value 3) while time_left=4 in COUNT -> no expired pulse, time_left reloads to 3.
REQ-034 Scenario: start_timer coincident with the final tick -> expired stays 0 and a new fetch begins.
REQ-035 Scenario: param_value=0 -> expired pulses in the LOAD cycle and the block returns to IDLE.
REQ-036 Scenario: sys_reset asserted asynchronously mid-count (time_left=3) -> outputs clear before the next clk edge, and no expired pulse follows.

Source files
------------

// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: parameter-store address codes
// and the controller state encoding.
package interval_timer_pkg;

    localparam logic [1:0] ADDR_BASE = 2'b00;
    localparam logic [1:0] ADDR_EXTD = 2'b01;
    localparam logic [1:0] ADDR_YELL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        LOAD  = 2'b10,
        COUNT = 2'b11
    } timer_state_t;

endpackage

// File: rtl/interval_timer.sv
// Interval timer: fetches an interval length from the parameter store and
// counts it down on 1 Hz ticks, pulsing expired when it elapses.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start_timer; time_left holds its last value
//   FETCH | address presented to the store; waiting for prg_sync_in low
//   LOAD  | store read data valid; copy into time_left
//   COUNT | decrement time_left on each one_hz_enable until it reaches 0
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic               start_timer,
    input  logic [1:0]         interval_sel,
    input  logic               prg_sync_in,
    input  logic [COUNT_W-1:0] param_value,
    input  logic               one_hz_enable,
    output logic [1:0]         interval_address,
    output logic               busy,
    output logic [COUNT_W-1:0] time_left,
    output logic               expired
);

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    timer_state_t state, state_nxt;
    logic         load_addr;
    logic         load_time;
    logic         dec_time;
    logic         fire;

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start request takes priority over everything else, so a restart that
    // coincides with the final tick or a zero-length load never fires.
    always_comb begin
        state_nxt = state;
        load_addr = 1'b0;
        load_time = 1'b0;
        dec_time  = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (start_timer) begin
                    load_addr = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (start_timer) begin
                    load_addr = 1'b1;
                end else if (!prg_sync_in) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (start_timer) begin
                    load_addr = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    load_time = 1'b1;
                    if (param_value == '0) begin
                        fire      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = COUNT;
                    end
                end
            end
            COUNT: begin
                if (start_timer) begin
                    load_addr = 1'b1;
                    state_nxt = FETCH;
                end else if (one_hz_enable) begin
                    dec_time = (time_left != '0);
                    if (time_left <= ONE) begin
                        fire      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            interval_address <= ADDR_BASE;
            time_left        <= '0;
            expired          <= 1'b0;
        end else begin
            expired <= fire;
            if (load_addr) begin
                interval_address <= interval_sel;
            end
            if (load_time) begin
                time_left <= param_value;
            end else if (dec_time) begin
                time_left <= time_left - ONE;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a small registered parameter-store model.
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic       prg_sync_in;
    logic [3:0] param_value;
    logic       one_hz_enable;
    logic [1:0] interval_address;
    logic       busy;
    logic [3:0] time_left;
    logic       expired;

    logic [3:0] mem [4];
    int n_cmp = 0;
    int n_bad = 0;

    interval_timer #(.COUNT_W(4)) dut (
        .clk              (clk),
        .sys_reset        (sys_reset),
        .start_timer      (start_timer),
        .interval_sel     (interval_sel),
        .prg_sync_in      (prg_sync_in),
        .param_value      (param_value),
        .one_hz_enable    (one_hz_enable),
        .interval_address (interval_address),
        .busy             (busy),
        .time_left        (time_left),
        .expired          (expired)
    );

    always #5 clk = ~clk;

    // Registered-read parameter store; output frozen while being reprogrammed.
    always @(posedge clk) begin
        if (!prg_sync_in) param_value <= mem[interval_address];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        mem[0] = 4'd6;
        mem[1] = 4'd3;
        mem[2] = 4'd2;
        mem[3] = 4'd15;
        sys_reset     = 1'b1;
        start_timer   = 1'b0;
        interval_sel  = 2'b00;
        prg_sync_in   = 1'b0;
        param_value   = 4'd0;
        one_hz_enable = 1'b0;

        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_time", 32'(time_left), 0);
        chk("rst_exp", 32'(expired), 0);
        chk("rst_addr", 32'(interval_address), 0);
        step();
        step();
        sys_reset = 1'b0;
        one_hz_enable = 1'b1;
        step();
        step();
        one_hz_enable = 1'b0;
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_time", 32'(time_left), 0);

        // Base interval: 6 ticks
        start_timer = 1'b1; interval_sel = 2'b00;
        step();
        start_timer = 1'b0;
        chk("s1_fetch_busy", 32'(busy), 1);
        chk("s1_addr", 32'(interval_address), 0);
        step();
        step();
        chk("s1_load", 32'(time_left), 6);
        chk("s1_busy", 32'(busy), 1);
        for (int i = 1; i <= 6; i++) begin
            one_hz_enable = 1'b1;
            step();
            one_hz_enable = 1'b0;
            chk("s1_tick", 32'(time_left), 32'(6 - i));
            chk("s1_exp", 32'(expired), (i == 6) ? 1 : 0);
            if (i == 1) begin
                step();
                chk("s1_hold", 32'(time_left), 5);
            end
        end
        chk("s1_idle", 32'(busy), 0);
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        chk("s1_exp_once", 32'(expired), 0);
        chk("s1_nowrap", 32'(time_left), 0);

        // Yellow interval with store frozen for 5 cycles
        prg_sync_in = 1'b1;
        start_timer = 1'b1; interval_sel = 2'b10;
        step();
        start_timer = 1'b0;
        chk("s2_addr", 32'(interval_address), 2);
        for (int i = 0; i < 4; i++) begin
            one_hz_enable = (i == 1);
            step();
            chk("s2_fetch_busy", 32'(busy), 1);
            chk("s2_fetch_time", 32'(time_left), 0);
        end
        one_hz_enable = 1'b0;
        prg_sync_in = 1'b0;
        step();
        step();
        chk("s2_load", 32'(time_left), 2);
        one_hz_enable = 1'b1;
        step();
        chk("s2_tick", 32'(time_left), 1);

        // Restart coincident with the final tick
        start_timer = 1'b1; interval_sel = 2'b01;
        step();
        start_timer = 1'b0; one_hz_enable = 1'b0;
        chk("s4_no_exp", 32'(expired), 0);
        chk("s4_busy", 32'(busy), 1);
        chk("s4_addr", 32'(interval_address), 1);
        step();
        chk("s4_no_exp2", 32'(expired), 0);
        step();
        chk("s4_reload", 32'(time_left), 3);

        // Restart with extended interval while time_left=4
        start_timer = 1'b1; interval_sel = 2'b00;
        step();
        start_timer = 1'b0;
        step();
        step();
        chk("s3_load6", 32'(time_left), 6);
        one_hz_enable = 1'b1;
        step();
        step();
        one_hz_enable = 1'b0;
        chk("s3_at4", 32'(time_left), 4);
        start_timer = 1'b1; interval_sel = 2'b01;
        step();
        start_timer = 1'b0;
        chk("s3_no_exp", 32'(expired), 0);
        step();
        chk("s3_no_exp2", 32'(expired), 0);
        step();
        chk("s3_reload", 32'(time_left), 3);

        // Undefined select passes straight through
        start_timer = 1'b1; interval_sel = 2'b11;
        step();
        start_timer = 1'b0;
        chk("s23_addr", 32'(interval_address), 3);
        step();
        step();
        chk("s23_load", 32'(time_left), 15);
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        chk("s23_tick", 32'(time_left), 14);

        // Async reset mid-count at time_left=3
        start_timer = 1'b1; interval_sel = 2'b01;
        step();
        start_timer = 1'b0;
        step();
        step();
        chk("s36_at3", 32'(time_left), 3);
        #2;
        sys_reset = 1'b1;
        #1;
        chk("s36_time", 32'(time_left), 0);
        chk("s36_busy", 32'(busy), 0);
        chk("s36_addr", 32'(interval_address), 0);
        chk("s36_exp", 32'(expired), 0);
        step();
        sys_reset = 1'b0;
        one_hz_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s36_quiet_exp", 32'(expired), 0);
            chk("s36_quiet_busy", 32'(busy), 0);
        end
        one_hz_enable = 1'b0;

        // Zero-length interval
        mem[0] = 4'd0;
        start_timer = 1'b1; interval_sel = 2'b00;
        step();
        start_timer = 1'b0;
        step();
        chk("s35_pre_exp", 32'(expired), 0);
        step();
        chk("s35_exp", 32'(expired), 1);
        chk("s35_idle", 32'(busy), 0);
        chk("s35_time", 32'(time_left), 0);
        step();
        chk("s35_exp_end", 32'(expired), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
